// File: rtl/sha2_host_pkg.sv
// Shared definitions for the SHA-256 host register file: address map,
// engine status codes, sequencer states and CSR layout.
package sha2_host_pkg;

    localparam logic [4:0] ADDR_PT0    = 5'h00;
    localparam logic [4:0] ADDR_LEN_LO = 5'h0E;
    localparam logic [4:0] ADDR_LEN_HI = 5'h0F;
    localparam logic [4:0] ADDR_CTRL   = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h11;
    localparam logic [4:0] ADDR_DIG0   = 5'h18;

    localparam logic [2:0] SHA_ST_BUSY = 3'd2;
    localparam logic [2:0] SHA_ST_DONE = 3'd1;

    localparam int CSR_START_BIT = 66;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_BUSY    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

    // Message words and length share one contiguous, write-protected window.
    function automatic logic is_msg_addr(input logic [4:0] addr);
        return addr <= ADDR_LEN_HI;
    endfunction

    function automatic logic is_dig_addr(input logic [4:0] addr);
        return addr >= ADDR_DIG0;
    endfunction

endpackage

// File: rtl/sha2_host_timeout.sv
// Loadable cycle counter that flags when the engine has been outstanding
// for TIMEOUT_CYCLES cycles.
module sha2_host_timeout #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic clock,
    input  logic reset_n,
    input  logic srst,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_r;

    // Cycle counter: cleared by srst, advances while enabled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (srst) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Terminal value is one short so the state leaves on the TIMEOUT_CYCLES-th edge.
    assign expired = en && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sha2_host_regfile.sv
// Host register file and sequencer: collects message and length, pulses the
// engine start bit, tracks engine status and captures the digest.
module sha2_host_regfile
    import sha2_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         host_wr,
    input  logic         host_rd,
    input  logic [4:0]   host_addr,
    input  logic [31:0]  host_wdata,
    output logic [31:0]  host_rdata,
    output logic         host_rvalid,
    output logic         irq,
    output logic [447:0] plaintext,
    output logic [66:0]  sha2CSR,
    input  logic [255:0] digest,
    input  logic [2:0]   sha2CSR_o,
    input  logic         regwrite,
    input  logic         csrUpdate
);

    state_e            state_r, state_nxt_s;
    logic [0:13][31:0] pt_r;
    logic [0:7][31:0]  dig_r;
    logic [63:0]       len_r;
    logic [2:0]        code_r;
    logic [31:0]       rdata_r, rd_mux_s;
    logic              err_timeout_r, err_wr_busy_r, irq_en_r, irq_r, start_r, rvalid_r;
    logic              busy_s, done_s, expired_s, ctrl_wr_s, start_req_s, clear_req_s;
    logic              msg_wr_s, flag_clr_s, irq_en_nxt_s, cnt_en_s, cnt_load_s;

    assign busy_s       = (state_r == ST_START) || (state_r == ST_BUSY) || (state_r == ST_CAPTURE);
    assign done_s       = (state_r == ST_DONE);
    assign ctrl_wr_s    = host_wr && (host_addr == ADDR_CTRL);
    assign start_req_s  = ctrl_wr_s && host_wdata[0];
    assign clear_req_s  = ctrl_wr_s && host_wdata[1];
    assign msg_wr_s     = host_wr && is_msg_addr(host_addr);
    assign flag_clr_s   = ((state_r == ST_DONE) || (state_r == ST_ERR)) && (start_req_s || clear_req_s);
    assign irq_en_nxt_s = irq_en_r || (ctrl_wr_s && host_wdata[2]);
    assign cnt_load_s   = (state_r == ST_START);
    assign cnt_en_s     = (state_r == ST_BUSY) || (state_r == ST_CAPTURE);

    sha2_host_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clock  (clock),
        .reset_n(reset_n),
        .srst   (cnt_load_s),
        .en     (cnt_en_s),
        .expired(expired_s)
    );

    // Sequencer next state; a timeout takes priority over engine strobes
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_req_s) state_nxt_s = ST_START;
                else             state_nxt_s = ST_IDLE;
            end
            ST_START: state_nxt_s = ST_BUSY;
            ST_BUSY: begin
                if (expired_s)     state_nxt_s = ST_ERR;
                else if (regwrite) state_nxt_s = ST_CAPTURE;
                else               state_nxt_s = ST_BUSY;
            end
            ST_CAPTURE: begin
                if (expired_s)                                      state_nxt_s = ST_ERR;
                else if (csrUpdate && (sha2CSR_o == SHA_ST_DONE))   state_nxt_s = ST_DONE;
                else                                                state_nxt_s = ST_CAPTURE;
            end
            ST_DONE, ST_ERR: begin
                if (start_req_s)      state_nxt_s = ST_START;
                else if (clear_req_s) state_nxt_s = ST_IDLE;
                else                  state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state, start pulse and interrupt registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            start_r  <= 1'b0;
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            start_r  <= (state_nxt_s == ST_START);
            irq_en_r <= irq_en_nxt_s;
            irq_r    <= irq_en_nxt_s && ((state_nxt_s == ST_DONE) || (state_nxt_s == ST_ERR));
        end
    end

    // Message/length storage, digest capture, engine status and error flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pt_r          <= '0;
            len_r         <= 64'd0;
            dig_r         <= '0;
            code_r        <= 3'd0;
            err_timeout_r <= 1'b0;
            err_wr_busy_r <= 1'b0;
        end else begin
            if (msg_wr_s && !busy_s) begin
                if (host_addr == ADDR_LEN_LO)      len_r[31:0]            <= host_wdata;
                else if (host_addr == ADDR_LEN_HI) len_r[63:32]           <= host_wdata;
                else                               pt_r[host_addr[3:0]]   <= host_wdata;
            end
            if ((state_r == ST_BUSY) && regwrite && !expired_s) begin
                dig_r <= digest;
            end
            if (csrUpdate) begin
                code_r <= sha2CSR_o;
            end
            if (flag_clr_s) begin
                err_timeout_r <= 1'b0;
                err_wr_busy_r <= 1'b0;
            end else begin
                if (expired_s)           err_timeout_r <= 1'b1;
                if (msg_wr_s && busy_s)  err_wr_busy_r <= 1'b1;
            end
        end
    end

    // Read mux sees pre-write register contents
    always_comb begin
        rd_mux_s = 32'h0;
        if (host_addr == ADDR_LEN_LO)      rd_mux_s = len_r[31:0];
        else if (host_addr == ADDR_LEN_HI) rd_mux_s = len_r[63:32];
        else if (is_msg_addr(host_addr))   rd_mux_s = pt_r[4'(host_addr - ADDR_PT0)];
        else if (host_addr == ADDR_STATUS) rd_mux_s = {25'h0, code_r, err_wr_busy_r, err_timeout_r, done_s, busy_s};
        else if (is_dig_addr(host_addr))   rd_mux_s = dig_r[host_addr[2:0]];
        else                               rd_mux_s = 32'h0;
    end

    // One-cycle read response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r  <= 32'h0;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= host_rd;
            if (host_rd) rdata_r <= rd_mux_s;
        end
    end

    // Engine command word: start pulse over a fixed-zero field and the length
    always_comb begin
        sha2CSR                = {3'b000, len_r};
        sha2CSR[CSR_START_BIT] = start_r;
    end

    assign plaintext   = pt_r;
    assign host_rdata  = rdata_r;
    assign host_rvalid = rvalid_r;
    assign irq         = irq_r;

endmodule

// File: tb/tb_sha2_host_regfile.sv
// Randomised bench for sha2_host_regfile: an engine model answers start pulses
// and a transaction-level reference model is compared every cycle.
module tb_sha2_host_regfile;

    localparam int TMO = 16;
    localparam int PH_IDLE = 0, PH_START = 1, PH_BUSY = 2, PH_CAP = 3, PH_DONE = 4, PH_ERR = 5;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         host_wr, host_rd;
    logic [4:0]   host_addr;
    logic [31:0]  host_wdata, host_rdata;
    logic         host_rvalid, irq;
    logic [447:0] plaintext;
    logic [66:0]  sha2CSR;
    logic [255:0] digest;
    logic [2:0]   sha2CSR_o;
    logic         regwrite, csrUpdate;

    always #5 clock = ~clock;

    sha2_host_regfile #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .host_wr(host_wr), .host_rd(host_rd),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .irq(irq), .plaintext(plaintext), .sha2CSR(sha2CSR),
        .digest(digest), .sha2CSR_o(sha2CSR_o), .regwrite(regwrite), .csrUpdate(csrUpdate)
    );

    logic [31:0] abc_w [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    // ---------------- reference model ----------------
    int          m_phase;
    logic [31:0] m_pt [14];
    logic [31:0] m_dig [8];
    logic [63:0] m_len;
    logic [2:0]  m_code;
    logic [31:0] m_rdata;
    logic        m_err_to, m_err_wb, m_irq_en, m_irq, m_start, m_rvalid;
    longint      cyc, busy_since;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic b;
        b = (m_phase == PH_START) || (m_phase == PH_BUSY) || (m_phase == PH_CAP);
        if (a <= 5'd13)      return m_pt[a];
        else if (a == 5'd14) return m_len[31:0];
        else if (a == 5'd15) return m_len[63:32];
        else if (a == 5'd17) return {25'd0, m_code, m_err_wb, m_err_to, (m_phase == PH_DONE), b};
        else if (a >= 5'd24) return m_dig[a - 5'd24];
        else                 return 32'd0;
    endfunction

    function automatic logic [447:0] exp_pt();
        logic [447:0] r;
        for (int i = 0; i < 14; i++) r[447 - 32*i -: 32] = m_pt[i];
        return r;
    endfunction

    task automatic m_reset();
        m_phase = PH_IDLE; m_len = 64'd0; m_code = 3'd0; m_rdata = 32'd0;
        m_err_to = 1'b0; m_err_wb = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
        m_start = 1'b0; m_rvalid = 1'b0; cyc = 0; busy_since = 0;
        for (int i = 0; i < 14; i++) m_pt[i] = 32'd0;
        for (int i = 0; i < 8; i++)  m_dig[i] = 32'd0;
    endtask

    task automatic m_step();
        logic busy, ctrl, tmo, st, cl;
        cyc++;
        busy = (m_phase == PH_START) || (m_phase == PH_BUSY) || (m_phase == PH_CAP);
        m_rvalid = host_rd;
        if (host_rd) m_rdata = m_read(host_addr);
        ctrl = host_wr && (host_addr == 5'h10);
        st = ctrl && host_wdata[0];
        cl = ctrl && host_wdata[1];
        if (ctrl && host_wdata[2]) m_irq_en = 1'b1;
        if (host_wr && host_addr <= 5'h0F) begin
            if (busy)                  m_err_wb = 1'b1;
            else if (host_addr == 5'd14) m_len[31:0] = host_wdata;
            else if (host_addr == 5'd15) m_len[63:32] = host_wdata;
            else                       m_pt[host_addr] = host_wdata;
        end
        if (csrUpdate) m_code = sha2CSR_o;
        tmo = ((m_phase == PH_BUSY) || (m_phase == PH_CAP)) && (cyc - busy_since == longint'(TMO));
        case (m_phase)
            PH_IDLE:  if (st) m_phase = PH_START;
            PH_START: begin m_phase = PH_BUSY; busy_since = cyc; end
            PH_BUSY: begin
                if (tmo) begin m_phase = PH_ERR; m_err_to = 1'b1; end
                else if (regwrite) begin
                    for (int i = 0; i < 8; i++) m_dig[i] = digest[255 - 32*i -: 32];
                    m_phase = PH_CAP;
                end
            end
            PH_CAP: begin
                if (tmo) begin m_phase = PH_ERR; m_err_to = 1'b1; end
                else if (csrUpdate && sha2CSR_o == 3'd1) m_phase = PH_DONE;
            end
            default: begin
                if (st || cl) begin
                    m_phase = st ? PH_START : PH_IDLE;
                    m_err_to = 1'b0; m_err_wb = 1'b0;
                end
            end
        endcase
        m_start = (m_phase == PH_START);
        m_irq = m_irq_en && ((m_phase == PH_DONE) || (m_phase == PH_ERR));
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m_reset();
        else          m_step();
    end

    // ---------------- engine model ----------------
    int   eng_mode = 1, eng_lat = 6, stray_req = 0, stray_ack = 0;
    logic eng_rand = 1'b0;

    initial begin
        int mode, lat;
        regwrite = 1'b0; csrUpdate = 1'b0; sha2CSR_o = 3'd0; digest = '0;
        forever begin
            @(negedge clock);
            if (stray_ack != stray_req) begin
                stray_ack = stray_req;
                digest = '1; regwrite = 1'b1;
                @(negedge clock);
                regwrite = 1'b0;
            end else if (reset_n && sha2CSR[66]) begin
                mode = eng_rand ? (($urandom_range(0, 3) == 0) ? 2 : 1) : eng_mode;
                lat  = eng_rand ? int'($urandom_range(1, 6)) : eng_lat;
                repeat (lat) @(negedge clock);
                csrUpdate = 1'b1; sha2CSR_o = 3'd2;
                @(negedge clock);
                csrUpdate = 1'b0;
                if (mode == 1) begin
                    repeat (eng_rand ? int'($urandom_range(0, 3)) : 2) @(negedge clock);
                    for (int i = 0; i < 8; i++)
                        digest[255 - 32*i -: 32] = eng_rand ? $urandom : abc_w[i];
                    regwrite = 1'b1;
                    @(negedge clock);
                    regwrite = 1'b0; csrUpdate = 1'b1; sha2CSR_o = 3'd1;
                    @(negedge clock);
                    csrUpdate = 1'b0;
                end
            end
        end
    end

    // ---------------- checking and stimulus ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        host_wr = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clock);
        host_wr = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        host_rd = 1'b1; host_addr = a;
        @(negedge clock);
        host_rd = 1'b0;
        d = host_rdata;
    endtask

    initial begin
        reset_n = 1'b0; host_wr = 1'b0; host_rd = 1'b0; host_addr = 5'd0; host_wdata = 32'd0;
        fork
            begin
                forever begin
                    @(negedge clock);
                    chk("plaintext", plaintext, exp_pt());
                    chk("sha2CSR", 448'(sha2CSR), 448'({m_start, 2'b00, m_len}));
                    chk("irq", 448'(irq), 448'(m_irq));
                    chk("rvalid", 448'(host_rvalid), 448'(m_rvalid));
                    if (m_rvalid) chk("rdata", 448'(host_rdata), 448'(m_rdata));
                end
            end
            begin
                logic [31:0] d;
                int n;
                repeat (2) @(negedge clock);
                #2 reset_n = 1'b1;
                @(negedge clock);
                rd(5'h11, d); chk("reset_status", 448'(d), 448'(0));
                rd(5'h00, d); chk("reset_pt0", 448'(d), 448'(0));

                // "abc" message
                wr(5'h00, 32'h61626380);
                for (int i = 1; i < 14; i++) wr(5'(i), 32'h0);
                wr(5'h0E, 32'h18); wr(5'h0F, 32'h0);
                wr(5'h10, 32'h1);
                chk("start_pulse", 448'(sha2CSR[66]), 448'(1));
                @(negedge clock);
                chk("start_single", 448'(sha2CSR[66]), 448'(0));
                rd(5'h11, d); chk("busy_bit", 448'(d[0]), 448'(1));
                wr(5'h03, 32'hDEADBEEF);
                wr(5'h10, 32'h1);
                chk("no_restart", 448'(sha2CSR[66]), 448'(0));
                n = 0; d = 32'h0;
                while (!d[1] && n < 40) begin rd(5'h11, d); n++; end
                chk("abc_done_status", 448'(d), 448'(32'h1A));
                rd(5'h03, d); chk("word3_kept", 448'(d), 448'(0));
                for (int i = 0; i < 8; i++) begin
                    rd(5'(24 + i), d); chk("abc_digest", 448'(d), 448'(abc_w[i]));
                end

                // back-to-back reads: last digest word then an unmapped address
                host_rd = 1'b1; host_addr = 5'h1F;
                @(negedge clock);
                chk("rv_1f", 448'(host_rvalid), 448'(1)); chk("rd_1f", 448'(host_rdata), 448'(32'hf20015ad));
                host_addr = 5'h12;
                @(negedge clock);
                host_rd = 1'b0;
                chk("rv_12", 448'(host_rvalid), 448'(1)); chk("rd_12", 448'(host_rdata), 448'(0));
                @(negedge clock);
                chk("rv_drop", 448'(host_rvalid), 448'(0));

                // engine hangs: timeout with interrupt enabled
                eng_mode = 2; eng_lat = 2;
                wr(5'h10, 32'h5);
                n = 0;
                while (!irq && n < 40) begin @(negedge clock); n++; end
                chk("tmo_latency", 448'(n), 448'(17));
                rd(5'h11, d); chk("tmo_status", 448'(d), 448'(32'h24));
                chk("tmo_irq", 448'(irq), 448'(1));
                wr(5'h10, 32'h2);
                chk("clr_irq", 448'(irq), 448'(0));
                rd(5'h11, d); chk("clr_status", 448'(d), 448'(32'h20));

                // asynchronous reset while busy
                wr(5'h10, 32'h1);
                repeat (6) @(negedge clock);
                rd(5'h11, d); chk("pre_rst_busy", 448'(d[0]), 448'(1));
                #2 reset_n = 1'b0;
                #1;
                chk("rst_pt", plaintext, 448'(0));
                chk("rst_csr", 448'(sha2CSR), 448'(0));
                chk("rst_out", 448'({irq, host_rvalid, host_rdata}), 448'(0));
                @(negedge clock);
                #2 reset_n = 1'b1;
                @(negedge clock);
                rd(5'h11, d); chk("rst_status", 448'(d), 448'(0));
                rd(5'h18, d); chk("rst_digest", 448'(d), 448'(0));

                // stray digest strobe while idle
                stray_req++;
                repeat (4) @(negedge clock);
                rd(5'h18, d); chk("stray_digest", 448'(d), 448'(0));
                rd(5'h11, d); chk("stray_status", 448'(d), 448'(0));

                // randomised traffic against the model
                eng_rand = 1'b1;
                for (int k = 0; k < 600; k++) begin
                    case ($urandom_range(0, 15))
                        0, 1: wr(5'h10, 32'($urandom_range(0, 7)));
                        2, 3, 4, 5: wr(5'($urandom_range(0, 31)), $urandom);
                        6, 7, 8, 9: rd(5'($urandom_range(0, 31)), d);
                        10: begin
                            host_wr = 1'b1; host_rd = 1'b1;
                            host_addr = 5'($urandom_range(0, 17)); host_wdata = $urandom;
                            @(negedge clock);
                            host_wr = 1'b0; host_rd = 1'b0;
                        end
                        11: begin stray_req++; @(negedge clock); end
                        12: begin
                            if ($urandom_range(0, 30) == 0) begin
                                #2 reset_n = 1'b0;
                                @(negedge clock);
                                #2 reset_n = 1'b1;
                            end
                            @(negedge clock);
                        end
                        default: @(negedge clock);
                    endcase
                end
                repeat (4) @(negedge clock);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join
    end

endmodule

// File: doc/sha2_host_regfile.md
Name: sha2_host_regfile

Overview:
- Host-side register file and sequencer that drives the SHA-256 wrapper from the opposite end.
- Collects a 448-bit message and a 64-bit bit-length over a 32-bit register bus, then issues the single-cycle start command in the engine CSR.
- Tracks the engine's busy/done status codes and captures the 256-bit digest on the engine's write strobe.
- Exposes status and digest back to the host.

Parameters:
- TIMEOUT_CYCLES, 4096, cycles in BUSY without completion before the error flag is raised.
- CNT_W, 13, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- host_wr  in  1  host write strobe, one cycle per access.
- host_rd  in  1  host read strobe.
- host_addr  in  5  word address.
- host_wdata  in  32  write data.
- host_rdata  out  32  read data, valid when host_rvalid=1.
- host_rvalid  out  1  read-data-valid pulse.
- irq  out  1  level interrupt; high while DONE or ERR and irq_en=1.
- plaintext  out  448  message to engine; word0 maps to [447:416].
- sha2CSR  out  67  engine command: [66]=start pulse, [65:64]=2'b00, [63:0]=message length in bits.
- digest  in  256  engine hash output.
- sha2CSR_o  in  3  engine status code: 2=busy, 1=done, other values reserved.
- regwrite  in  1  engine digest-valid strobe.
- csrUpdate  in  1  engine status-valid strobe.

Behaviour:
Address map:
- 0x00–0x0D: plaintext words 0..13, read/write.
- 0x0E: length[31:0].
- 0x0F: length[63:32].
- 0x10: CTRL, write-only. bit0=start, bit1=clear, bit2=irq_en (irq_en is a sticky bit).
- 0x11: STATUS, read-only. bit0=busy, bit1=done, bit2=err_timeout, bit3=err_wr_busy, bits[6:4]=last sha2CSR_o.
- 0x18–0x1F: digest words 0..7; word0 = digest[255:224].
- Unmapped addresses: reads return 0, writes are ignored.

Reset (reset_n low, asynchronous):
- State=IDLE.
- All plaintext, length, and digest registers cleared to 0.
- sha2CSR=0, host_rdata=0, host_rvalid=0, irq=0, irq_en=0.
- All flags and the timeout counter cleared.

State machine: IDLE, START, BUSY, CAPTURE, DONE, ERR.
- IDLE: CTRL.start=1 -> START.
- START: exactly one cycle. Drive sha2CSR[66]=1, clear timeout counter -> BUSY. sha2CSR[66]=0 in every other state, so the engine never sees a repeated start.
- BUSY:
  - regwrite=1 latches digest into the digest registers -> CAPTURE.
  - Timeout counter increments every cycle. On reaching TIMEOUT_CYCLES, set err_timeout -> ERR.
- CAPTURE: csrUpdate=1 with sha2CSR_o=1 -> DONE. Timeout counter keeps running; a timeout here also -> ERR.
- DONE / ERR: hold until CTRL.clear=1 (-> IDLE) or CTRL.start=1 (-> START). Flags are cleared on the transition.

Engine status and digest capture:
- Any csrUpdate=1 latches sha2CSR_o into STATUS[6:4], in every state.
- regwrite outside BUSY is ignored; the digest registers are not overwritten.

Write protection and precedence:
- Host writes to 0x00–0x0F during START, BUSY, or CAPTURE are dropped and set err_wr_busy (sticky until clear or start).
- CTRL.start during START, BUSY, or CAPTURE is ignored.
- CTRL.start and clear written in the same cycle: start wins.
- plaintext and sha2CSR[63:0] are driven continuously from the registers; they are stable during START and BUSY because writes are blocked.

Host reads:
- One-cycle latency: host_rdata and host_rvalid update the cycle after host_rd.
- host_wr and host_rd asserted in the same cycle: the write is performed and the read returns pre-write data.

Derived signals:
- busy = state in {START, BUSY, CAPTURE}.
- done = state==DONE.
- irq = irq_en & (DONE | ERR).

Reset mid-operation:
- Everything returns to reset values immediately.
- Host must start the engine again; the engine is re-initialised by the next start pulse.

Decomposition:
- Shared package sha2_host_pkg holds:
  - address constants: ADDR_PT0, ADDR_LEN_LO, ADDR_LEN_HI, ADDR_CTRL, ADDR_STATUS, ADDR_DIG0;
  - status codes: SHA_ST_BUSY=3'd2, SHA_ST_DONE=3'd1;
  - the state enum;
  - the CSR bit index: CSR_START_BIT=66.
- One natural sub-module: sha2_host_timeout (loadable counter with a terminal flag).

Test Plan:
- "abc" hash: write padded word0=0x61626380, words1..13=0, length=0x18, then CTRL=0x1.
  - sha2CSR[66] high for exactly 1 cycle.
  - STATUS reads busy=1; then done=1 after the engine model finishes.
  - Digest words read 0xba7816bf, 0x8f01cfea, 0x414140de, 0x5dae2223, 0xb00361a3, 0x96177a9c, 0xb410ff61, 0xf20015ad.
- During BUSY: write 0xDEADBEEF to 0x03 -> word3 unchanged, STATUS bit3=1. Write CTRL.start -> no second start pulse.
- Engine model never asserts regwrite, TIMEOUT_CYCLES=16 -> err_timeout=1 exactly 16 cycles after entering BUSY. With irq_en=1, irq high. CTRL.clear -> IDLE, irq=0.
- Assert reset_n low for 1 cycle while in BUSY -> all outputs 0 asynchronously, STATUS=0, digest reads 0.
- Read 0x1F, then 0x12 (unmapped) -> host_rvalid pulses one cycle after each host_rd. Data = digest[31:0], then 0.
- Stray regwrite with digest=all-ones while IDLE -> digest registers unchanged, state remains IDLE.
